// File: rtl/mole_round_ctrl.sv
// Whack-a-mole game sequencer: gap/show rounds, LFSR hole selection, reaction-time scoring.
// Define MOLE_MISS_LIMIT_EN to end the game after MISS_LIMIT consecutive misses.
module mole_round_ctrl #(
    parameter int TICK_DIV   = 25000,
    parameter int GAP_MS     = 500,
    parameter int SLICE_MS   = 200,
    parameter int ROUNDS     = 20,
    parameter int NUM_HOLES  = 9,
    parameter int MISS_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] hole_hit,
    output logic [3:0]           mole_pos,
    output logic                 mole_visible,
    output logic                 hit_success,
    output logic [2:0]           round_score,
    output logic [4:0]           round_cnt,
    output logic                 score_clr,
    output logic                 busy,
    output logic                 game_over
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int MW = $clog2(GAP_MS + SLICE_MS + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GAP  = 3'd1,
        S_SHOW = 3'd2,
        S_HIT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_tick_cnt, w_tick_nxt;
    logic [MW-1:0] r_ms_cnt, w_ms_nxt, w_ms_run;
    logic [2:0]    r_slice, w_slice_nxt;
    logic [7:0]    r_lfsr;
    logic [4:0]    r_miss_cnt, w_miss_nxt;
    logic [3:0]    r_mole_pos, w_pos_nxt;
    logic [2:0]    r_round_score, w_score_nxt;
    logic [4:0]    r_round_cnt, w_round_nxt;
    logic          r_mole_visible, r_hit_success, r_score_clr, r_busy, r_game_over;
    logic          w_clr_nxt, w_tick, w_hit, w_limit;
    logic [3:0]    w_cand_raw, w_cand_mod, w_cand;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_hit  = |(hole_hit & (NUM_HOLES'(1'b1) << r_mole_pos));

`ifdef MOLE_MISS_LIMIT_EN
    assign w_limit = ((r_miss_cnt + 5'd1) == 5'(MISS_LIMIT));
`else
    assign w_limit = 1'b0;
`endif

    // Next hole: fold the LFSR nibble into range, then step past the previous hole.
    always_comb begin
        w_cand_raw = r_lfsr[3:0];
        if ({1'b0, w_cand_raw} >= 5'(NUM_HOLES)) begin
            w_cand_mod = w_cand_raw - 4'(NUM_HOLES);
        end else begin
            w_cand_mod = w_cand_raw;
        end
        if (w_cand_mod != r_mole_pos) begin
            w_cand = w_cand_mod;
        end else if ({1'b0, w_cand_mod} == 5'(NUM_HOLES - 1)) begin
            w_cand = 4'd0;
        end else begin
            w_cand = w_cand_mod + 4'd1;
        end
    end

    // Next-state and next-output logic for the game sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_ms_run    = w_tick ? r_ms_cnt + MW'(1) : r_ms_cnt;
        w_slice_nxt = r_slice;
        w_miss_nxt  = r_miss_cnt;
        w_pos_nxt   = r_mole_pos;
        w_score_nxt = r_round_score;
        w_round_nxt = r_round_cnt;
        w_clr_nxt   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_GAP;
                    w_clr_nxt   = 1'b1;
                    w_round_nxt = 5'd0;
                    w_miss_nxt  = 5'd0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_GAP: begin
                if (w_tick && (r_ms_cnt == MW'(GAP_MS - 1))) begin
                    w_state_nxt = S_SHOW;
                    w_pos_nxt   = w_cand;
                    w_slice_nxt = 3'd0;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            S_SHOW: begin
                // A press in the expiry cycle still counts, scored with the last slice.
                if (w_hit) begin
                    w_state_nxt = S_HIT;
                    w_score_nxt = 3'd5 - r_slice;
                    w_round_nxt = r_round_cnt + 5'd1;
                    w_miss_nxt  = 5'd0;
                end else if (w_tick && (r_ms_cnt == MW'(SLICE_MS - 1))) begin
                    w_ms_run = {MW{1'b0}};
                    if (r_slice == 3'd4) begin
                        w_round_nxt = r_round_cnt + 5'd1;
                        w_miss_nxt  = (r_miss_cnt == 5'(MISS_LIMIT)) ? r_miss_cnt : r_miss_cnt + 5'd1;
                        if (((r_round_cnt + 5'd1) == 5'(ROUNDS)) || w_limit) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_GAP;
                        end
                    end else begin
                        w_slice_nxt = r_slice + 3'd1;
                    end
                end else begin
                    w_state_nxt = S_SHOW;
                end
            end
            S_HIT: begin
                w_state_nxt = (r_round_cnt == 5'(ROUNDS)) ? S_DONE : S_GAP;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_state_nxt != r_state) begin
            w_tick_nxt = {TW{1'b0}};
            w_ms_nxt   = {MW{1'b0}};
        end else begin
            w_tick_nxt = w_tick ? {TW{1'b0}} : r_tick_cnt + TW'(1);
            w_ms_nxt   = w_ms_run;
        end
    end

    // State, counters, LFSR and registered outputs (outputs follow the next state).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_tick_cnt     <= {TW{1'b0}};
            r_ms_cnt       <= {MW{1'b0}};
            r_slice        <= 3'd0;
            r_lfsr         <= 8'hA5;
            r_miss_cnt     <= 5'd0;
            r_mole_pos     <= 4'd0;
            r_round_score  <= 3'd0;
            r_round_cnt    <= 5'd0;
            r_mole_visible <= 1'b0;
            r_hit_success  <= 1'b0;
            r_score_clr    <= 1'b0;
            r_busy         <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_tick_cnt     <= w_tick_nxt;
            r_ms_cnt       <= w_ms_nxt;
            r_slice        <= w_slice_nxt;
            r_lfsr         <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            r_miss_cnt     <= w_miss_nxt;
            r_mole_pos     <= w_pos_nxt;
            r_round_score  <= w_score_nxt;
            r_round_cnt    <= w_round_nxt;
            r_mole_visible <= (w_state_nxt == S_SHOW);
            r_hit_success  <= (w_state_nxt == S_HIT);
            r_score_clr    <= w_clr_nxt;
            r_busy         <= (w_state_nxt == S_GAP) || (w_state_nxt == S_SHOW) || (w_state_nxt == S_HIT);
            r_game_over    <= (w_state_nxt == S_DONE);
        end
    end

    assign mole_pos     = r_mole_pos;
    assign mole_visible = r_mole_visible;
    assign hit_success  = r_hit_success;
    assign round_score  = r_round_score;
    assign round_cnt    = r_round_cnt;
    assign score_clr    = r_score_clr;
    assign busy         = r_busy;
    assign game_over    = r_game_over;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// Scoreboard bench for mole_round_ctrl: hit scores and clear pulses are queued at stimulus time
// and popped by a negedge monitor; hole indices are predicted by an LFSR model.
module tb_mole_round_ctrl;
    localparam int NH = 9;

    logic          clk = 1'b0;
    logic          rst, start, start_b;
    logic [NH-1:0] hole_hit, hole_hit_b;
    logic [3:0]    mole_pos, mole_pos_b;
    logic          mole_visible, mole_visible_b, hit_success, hit_success_b;
    logic [2:0]    round_score, round_score_b;
    logic [4:0]    round_cnt, round_cnt_b;
    logic          score_clr, score_clr_b, busy, busy_b, game_over, game_over_b;

    int         n_vec = 0;
    int         n_err = 0;
    logic [2:0] q_score[$];
    bit         q_clr[$];

    always #5 clk = ~clk;

    mole_round_ctrl #(.TICK_DIV(4), .GAP_MS(2), .SLICE_MS(3), .ROUNDS(3), .NUM_HOLES(NH)) u_dut (
        .clk(clk), .rst(rst), .start(start), .hole_hit(hole_hit),
        .mole_pos(mole_pos), .mole_visible(mole_visible), .hit_success(hit_success),
        .round_score(round_score), .round_cnt(round_cnt), .score_clr(score_clr),
        .busy(busy), .game_over(game_over)
    );

    mole_round_ctrl #(.TICK_DIV(4), .GAP_MS(2), .SLICE_MS(3), .ROUNDS(10), .NUM_HOLES(NH)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .hole_hit(hole_hit_b),
        .mole_pos(mole_pos_b), .mole_visible(mole_visible_b), .hit_success(hit_success_b),
        .round_score(round_score_b), .round_cnt(round_cnt_b), .score_clr(score_clr_b),
        .busy(busy_b), .game_over(game_over_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference LFSR kept in lockstep with the DUT; prev holds the value used at the last edge.
    logic [7:0] m_lfsr, m_lfsr_prev;
    logic       rst_at_edge = 1'b0;
    always @(posedge clk) begin
        rst_at_edge <= rst;
        m_lfsr_prev <= m_lfsr;
        if (!rst) m_lfsr <= 8'hA5;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    int         mon_c;
    logic [3:0] mon_pos;
    logic       mon_prev_vis = 1'b0;
    logic [2:0] mon_exp;
    always @(negedge clk) begin
        if (!rst_at_edge) begin
            mon_pos      = 4'd0;
            mon_prev_vis = 1'b0;
        end else begin
            if (mole_visible && !mon_prev_vis) begin
                mon_c = int'(m_lfsr_prev[3:0]);
                if (mon_c >= NH) mon_c = mon_c - NH;
                if (mon_c == int'(mon_pos)) mon_c = (mon_c + 1) % NH;
                mon_pos = mon_c[3:0];
                check("mole_pos", int'(mole_pos), mon_c);
            end
            mon_prev_vis = mole_visible;
            if (hit_success) begin
                if (q_score.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL hit_success: unexpected pulse (got 1, required 0), round_score=%0d", round_score);
                end else begin
                    mon_exp = q_score.pop_front();
                    check("round_score", int'(round_score), int'(mon_exp));
                end
            end
            if (score_clr) begin
                n_vec++;
                if (q_clr.size() == 0) begin
                    n_err++;
                    $display("FAIL score_clr: unexpected pulse (got 1, required 0)");
                end else begin
                    void'(q_clr.pop_front());
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        check({tag, " mole_pos"}, int'(mole_pos), 0);
        check({tag, " mole_visible"}, int'(mole_visible), 0);
        check({tag, " hit_success"}, int'(hit_success), 0);
        check({tag, " round_score"}, int'(round_score), 0);
        check({tag, " round_cnt"}, int'(round_cnt), 0);
        check({tag, " score_clr"}, int'(score_clr), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " game_over"}, int'(game_over), 0);
    endtask

    task automatic wait_show(input string name, input int exp_cyc);
        int cnt = 0;
        while (mole_visible !== 1'b1 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check(name, cnt, exp_cyc);
    endtask

    // Press the mole's hole d cycles after it appeared; score = 5 - d/12 with these parameters.
    task automatic hit_round(input int d, input logic [2:0] exp_score, input int exp_rnd);
        logic [3:0] p;
        repeat (d) @(negedge clk);
        p = mole_pos;
        hole_hit = NH'(1) << p;
        q_score.push_back(exp_score);
        @(negedge clk);
        hole_hit = '0;
        check("mole_visible after hit", int'(mole_visible), 0);
        check("round_cnt after hit", int'(round_cnt), exp_rnd);
    endtask

    task automatic miss_round(input int exp_rnd, input logic [2:0] exp_score);
        int         cnt = 0;
        logic [3:0] w;
        w = (mole_pos == 4'(NH - 1)) ? 4'd0 : mole_pos + 4'd1;
        while (mole_visible === 1'b1 && cnt < 500) begin
            hole_hit = (cnt % 7 == 3) ? (NH'(1) << w) : '0;
            @(negedge clk);
            cnt++;
        end
        hole_hit = '0;
        check("show window length", cnt, 60);
        check("round_cnt after miss", int'(round_cnt), exp_rnd);
        check("round_score held on miss", int'(round_score), int'(exp_score));
    endtask

    task automatic b_round(input bit do_hit, input int exp_rnd, input int exp_gap);
        int cnt = 0;
        while (mole_visible_b !== 1'b1 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check("B gap length", cnt, exp_gap);
        if (do_hit) begin
            repeat (4) @(negedge clk);
            hole_hit_b = NH'(1) << mole_pos_b;
            @(negedge clk);
            hole_hit_b = '0;
            check("B hit_success", int'(hit_success_b), 1);
            check("B round_score", int'(round_score_b), 5);
        end else begin
            cnt = 0;
            while (mole_visible_b === 1'b1 && cnt < 500) begin
                @(negedge clk);
                cnt++;
            end
            check("B show window", cnt, 60);
        end
        check("B round_cnt", int'(round_cnt_b), exp_rnd);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start_b = 1'b0; hole_hit = '0; hole_hit_b = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Game 1: hit early, hit late (start held high during the gap), then a miss ends the game.
        start = 1'b1;
        q_clr.push_back(1'b1);
        @(negedge clk);
        start = 1'b0;
        check("busy after start", int'(busy), 1);
        check("round_cnt at start", int'(round_cnt), 0);
        wait_show("first gap", 8);
        hit_round(2, 3'd5, 1);
        start = 1'b1;
        wait_show("gap after hit", 9);
        start = 1'b0;
        hit_round(50, 3'd1, 2);
        wait_show("gap before miss", 9);
        miss_round(3, 3'd1);
        check("game_over after last round", int'(game_over), 1);
        check("busy after last round", int'(busy), 0);
        repeat (5) @(negedge clk);
        check("game_over held", int'(game_over), 1);

        // Game 2: restart from DONE, expiry-coincident press, mid-SHOW reset.
        start = 1'b1;
        q_clr.push_back(1'b1);
        @(negedge clk);
        start = 1'b0;
        check("restart round_cnt", int'(round_cnt), 0);
        check("restart game_over", int'(game_over), 0);
        check("restart busy", int'(busy), 1);
        wait_show("restart gap", 8);
        hit_round(59, 3'd1, 1);
        wait_show("gap 2", 9);
        hit_round(13, 3'd4, 2);
        wait_show("gap 3", 9);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("mid-game reset");
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        q_clr.push_back(1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_show("gap after reset", 8);
        hit_round(5, 3'd5, 1);

        // Instance B (ROUNDS=10): consecutive misses, then a hit between misses.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("B score_clr", int'(score_clr_b), 1);
        check("B busy", int'(busy_b), 1);
        b_round(1'b0, 1, 8);
        b_round(1'b0, 2, 8);
        b_round(1'b0, 3, 8);
`ifdef MOLE_MISS_LIMIT_EN
        check("B miss limit game_over", int'(game_over_b), 1);
        check("B miss limit busy", int'(busy_b), 0);
`else
        check("B continues after 3 misses", int'(game_over_b), 0);
        for (int r = 4; r <= 10; r++) b_round(1'b0, r, 8);
        check("B game_over after 10 rounds", int'(game_over_b), 1);
`endif
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("B restart round_cnt", int'(round_cnt_b), 0);
        b_round(1'b0, 1, 8);
        b_round(1'b1, 2, 8);
        b_round(1'b0, 3, 9);
        b_round(1'b0, 4, 8);
        check("B hit clears miss run", int'(game_over_b), 0);
        b_round(1'b0, 5, 8);
`ifdef MOLE_MISS_LIMIT_EN
        check("B third miss after hit", int'(game_over_b), 1);
`else
        check("B no limit without macro", int'(game_over_b), 0);
`endif

        repeat (3) @(negedge clk);
        check("pending hit expectations", q_score.size(), 0);
        check("pending clear expectations", q_clr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mole_round_ctrl.md
# mole_round_ctrl

- Game sequencer for the whack-a-mole datapath.
- Runs a fixed number of rounds. Each round has a gap, then one mole shown at a pseudo-random hole for a bounded window.
- Converts player reaction time into a 3-bit round score.
- Drives the score/display blocks with `hit_success` + `round_score` pulses and a clear pulse at game start.

## Interface
- `TICK_DIV`, 25000: clk cycles per 1 ms tick.
- `GAP_MS`, 500: ms with no mole between rounds.
- `SLICE_MS`, 200: ms per score slice; show window = 5 slices.
- `ROUNDS`, 20: rounds per game, 1..31.
- `NUM_HOLES`, 9: number of holes, 8..16.
- `MISS_LIMIT`, 3: consecutive misses ending the game (macro only).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `start`  in  1  game start request, level or pulse.
- `hole_hit`  in  NUM_HOLES  debounced one-cycle press pulses, bit i = hole i.
- `mole_pos`  out  4  active hole index.
- `mole_visible`  out  1  mole drawn at `mole_pos`.
- `hit_success`  out  1  one-cycle pulse: valid hit.
- `round_score`  out  3  points for the last hit (1..5); held until the next hit.
- `round_cnt`  out  5  completed rounds this game.
- `score_clr`  out  1  one-cycle pulse at game start; clears the score block.
- `busy`  out  1  game in progress.
- `game_over`  out  1  game finished; held until the next start.

## Operation
- FSM states: IDLE, GAP, SHOW, HIT, DONE. Reset → IDLE.
- **IDLE**
  - `start` → GAP; pulse `score_clr`; `round_cnt`=0.
- **GAP**
  - Lasts GAP_MS ticks.
  - On exit, select the new hole and enter SHOW with slice=0.
- **SHOW**
  - `mole_visible`=1.
  - `hole_hit[mole_pos]`=1 → HIT.
  - Presses on other holes are ignored.
  - Slice counter 0..4 advances every SLICE_MS ticks.
  - Expiry of slice 4 → miss: `round_cnt`+1, then GAP, or DONE if `round_cnt` reaches ROUNDS.
- **HIT** (exactly one cycle)
  - `hit_success`=1; `round_score`=5−slice; `round_cnt`+1.
  - Next state: GAP, or DONE if `round_cnt` reaches ROUNDS.
- **DONE**
  - `game_over`=1.
  - `start` → same actions as from IDLE.
- `busy`=1 in GAP, SHOW and HIT.
- `start` is ignored while `busy`.
- Hole selection:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, seeded 8'hA5 at reset, advances every cycle in all states.
  - candidate = lfsr[3:0]; if candidate ≥ NUM_HOLES, subtract NUM_HOLES.
  - If candidate equals the previous `mole_pos`, increment it modulo NUM_HOLES.
- Simultaneous correct press and window expiry in the same cycle: the hit wins, score 1.
- Reset asserted mid-game: IDLE next cycle; all outputs 0; LFSR reseeded.

## Timing
- Reset values: `mole_pos`=0, `mole_visible`=0, `hit_success`=0, `round_score`=0, `round_cnt`=0, `score_clr`=0, `busy`=0, `game_over`=0.
- All outputs are registered.
- Tick prescaler clears on every state transition, so durations are exact:
  - GAP = GAP_MS·TICK_DIV cycles.
  - Full SHOW window = 5·SLICE_MS·TICK_DIV cycles.
- `score_clr` and `busy` rise 1 cycle after `start` is sampled.
- `mole_visible`/`mole_pos` update on the GAP→SHOW edge.
- `mole_visible` falls on leaving SHOW.
- Correct press sampled at cycle t:
  - t+1: `hit_success`=1, `round_score` valid, `mole_visible`=0.
  - t+2: GAP entered.
- Spacing between `hit_success` pulses is always ≥ GAP + 1 cycles. This is at least 5 cycles, which the score block needs to drain its add buffer.
- `round_cnt` updates in the cycle that leaves SHOW (miss) or the HIT cycle.

## Configuration
- **`MOLE_MISS_LIMIT_EN` defined:**
  - Counts consecutive misses; cleared by any hit and by start.
  - Reaching MISS_LIMIT → DONE immediately, regardless of `round_cnt`.
- **Undefined:**
  - Misses only advance `round_cnt`.
  - The game always runs ROUNDS rounds.

## Test plan
All scenarios use TICK_DIV=4, GAP_MS=2, SLICE_MS=3, ROUNDS=3, NUM_HOLES=9, unless noted.
1. Reset, then pulse `start`:
   - `score_clr`=1 for exactly 1 cycle; `busy`=1.
   - `mole_visible` rises 8 cycles after GAP entry; `mole_pos`<9.
2. Press the correct hole 2 cycles into SHOW:
   - One-cycle `hit_success` with `round_score`=5.
   - In the next round, press 50 cycles into SHOW (slice 4): `round_score`=1.
3. Press only wrong holes during SHOW:
   - No `hit_success`; `mole_visible` falls after 60 cycles.
   - `round_cnt` increments; `round_score` keeps its previous value.
4. Complete 3 rounds:
   - `game_over`=1, `busy`=0.
   - `start` → `score_clr` pulse, `round_cnt`=0, `game_over`=0.
   - `start` held high during a game has no effect.
5. Drive `rst`=0 in the middle of SHOW:
   - Next cycle all outputs are 0 and the FSM is in IDLE.
   - After reset release, the first selected hole matches the post-seed LFSR value.
6. ROUNDS=10, three consecutive misses:
   - With `MOLE_MISS_LIMIT_EN`: `game_over` after `round_cnt`=3.
   - Without it: the game continues to `round_cnt`=10.
   - A hit between misses resets the count (macro build).
